alu_op_seq: RTL and testbench
=============================

ALU_OP_SEQ -- requirements
Module: alu_op_seq

Interface
REQ-001 Parameter W_WORDS, default 4, number of word steps in a chained add/sub operation (1..16).
REQ-002 Parameter MULT_BITS, default 8, number of multiplier bits iterated in multiply mode (1..32).
REQ-003 Parameter SW, default clog2(max(W_WORDS,MULT_BITS)) (minimum 1), width of step_idx.
REQ-004 clk  input  1  single clock; every register samples on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 start  input  1  request a new operation; sampled only in IDLE.
REQ-007 mult_sel  input  1  0 = add/sub chain, 1 = shift-add multiply sequence.
REQ-008 mode  input  2  add/sub mode: 00 add, 01 add-with-carry, 10 sub, 11 sub-with-borrow.
REQ-009 cin  input  1  external carry for modes 01/11, sampled with start.
REQ-010 multiplier  input  MULT_BITS  multiplier operand, sampled with start.
REQ-011 unit_cout  input  1  carry-out returned by the add/sub unit in the same cycle as step_valid.
REQ-012 flush  input  1  synchronous abort back to IDLE.
REQ-013 op_out  output  1  registered add(0)/sub(1) select to the add/sub unit.
REQ-014 cout  output  1  registered carry-in to the add/sub unit.
REQ-015 step_valid  output  1  high for each cycle a step is issued.
REQ-016 step_idx  output  SW  index of current step, 0-based.
REQ-017 busy  output  1  high in RUN and DONE.
REQ-018 done  output  1  one-cycle completion pulse.
REQ-019 carry_flag  output  1  final carry of last completed operation, held until next done.

Function
REQ-020 FSM states IDLE, RUN, DONE; IDLE->RUN on start&!flush; RUN->DONE after last step; DONE->IDLE unconditionally next cycle.
REQ-021 start sampled in IDLE latches mult_sel, mode, cin, multiplier; first step issued the following cycle (latency 1).
REQ-022 start while busy is ignored; no queuing.
REQ-023 Add/sub step 0: op_out=mode[1]; cout = 0 (00), cin (01), 1 (10), ~cin (11).
REQ-024 Add/sub step k>0: op_out=mode[1], cout = unit_cout captured at step k-1.
REQ-025 Add/sub runs exactly W_WORDS steps; carry_flag = unit_cout of step W_WORDS-1, updated on entry to DONE.
REQ-026 Multiply runs exactly MULT_BITS steps; step k: op_out = multiplier[k] (LSB first), cout = 0; carry_flag = 0 on entry to DONE.
REQ-027 step_idx increments by 1 per RUN cycle, 0 in IDLE/DONE; no wrap within an operation.
REQ-028 done=1 only in DONE; step_valid=1 only in RUN.
REQ-029 In IDLE and DONE, op_out=0, cout=0.
REQ-030 flush in any state: next cycle IDLE, all outputs 0 except carry_flag (held); flush has priority over start in the same cycle.
REQ-031 W_WORDS=1 or MULT_BITS=1: single RUN cycle, then DONE.
REQ-032 unit_cout ignored outside RUN and in multiply mode.

Reset
REQ-033 rst_n=0 at a clock edge forces IDLE, op_out=0, cout=0, step_valid=0, step_idx=0, busy=0, done=0, carry_flag=0, latched operands 0.
REQ-034 Reset mid-operation abandons it; no done pulse is produced.

Structure
REQ-035 Package alu_op_pkg holds the FSM state enum and mode encodings (ADD, ADC, SUB, SBC).
REQ-036 Step-0 op/carry decode is a combinational sub-module alu_carry_dec (inputs mult_sel, mode, cin, mult bit; outputs op, carry).

Verification
REQ-037 W_WORDS=4, start mode=00: op_out=0 four cycles, cout 0 then each prior unit_cout; unit_cout=1,0,1,1 -> carry_flag=1, done one cycle after step 3.
REQ-038 mode=11, cin=1: step 0 op_out=1, cout=0; mode=11, cin=0: step 0 cout=1.
REQ-039 mult_sel=1, multiplier=8'hA5: op_out sequence 1,0,1,0,0,1,0,1, cout=0 throughout, carry_flag=0.
REQ-040 flush asserted at step 2 -> IDLE next cycle, no done, carry_flag unchanged.
REQ-041 start held high continuously: operations back-to-back with one IDLE cycle between DONE and next RUN; starts during busy ignored.
REQ-042 rst_n low mid-RUN for one cycle -> all outputs 0 next cycle, no done pulse.

Source files
------------

// File: rtl/alu_op_seq_pkg.sv
// Shared types for the add/sub chain and shift-add multiply step sequencer.
package alu_op_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    ADD = 2'b00,
    ADC = 2'b01,
    SUB = 2'b10,
    SBC = 2'b11
  } mode_e;

  // Width of step_idx: enough to count the longer of the two sequences, never below 1.
  function automatic int unsigned sw_calc(int unsigned w_words, int unsigned mult_bits);
    int unsigned mx;
    mx = (w_words > mult_bits) ? w_words : mult_bits;
    return (mx <= 2) ? 1 : $clog2(mx);
  endfunction

endpackage

// File: rtl/alu_op_seq_if.sv
// Request/step bus between a requester (master) and the sequencer (slave).
interface alu_op_seq_if #(
  parameter int unsigned MULT_BITS = 8,
  parameter int unsigned SW        = 3
);

  logic                 start;
  logic                 mult_sel;
  logic [1:0]           mode;
  logic                 cin;
  logic [MULT_BITS-1:0] multiplier;
  logic                 unit_cout;
  logic                 flush;
  logic                 op_out;
  logic                 cout;
  logic                 step_valid;
  logic [SW-1:0]        step_idx;
  logic                 busy;
  logic                 done;
  logic                 carry_flag;

  modport master (
    output start, mult_sel, mode, cin, multiplier, unit_cout, flush,
    input  op_out, cout, step_valid, step_idx, busy, done, carry_flag
  );

  modport slave (
    input  start, mult_sel, mode, cin, multiplier, unit_cout, flush,
    output op_out, cout, step_valid, step_idx, busy, done, carry_flag
  );

endinterface

// File: rtl/alu_op_seq_carry_dec.sv
// Op-select and carry-in decode for an issued step.
module alu_carry_dec
  import alu_op_pkg::*;
(
  input  logic       mult_sel,
  input  logic [1:0] mode,
  input  logic       cin,
  input  logic       mult_bit,
  output logic       op,
  output logic       carry
);

  always_comb begin
    op    = mult_sel ? mult_bit : mode[1];
    carry = 1'b0;
    if (!mult_sel) begin
      case (mode_e'(mode))
        ADD:     carry = 1'b0;
        ADC:     carry = cin;
        SUB:     carry = 1'b1;
        SBC:     carry = ~cin;
        default: carry = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/alu_op_seq.sv
// Sequences a multi-word add/sub chain or a shift-add multiply, one step per cycle,
// driving a registered op/carry pair to an external add/sub unit.
module alu_op_seq
  import alu_op_pkg::*;
#(
  parameter int unsigned W_WORDS   = 4,
  parameter int unsigned MULT_BITS = 8,
  parameter int unsigned SW        = sw_calc(W_WORDS, MULT_BITS)
) (
  input logic         clk,
  input logic         rst_n,
  alu_op_seq_if.slave bus
);

  localparam logic [SW-1:0] LAST_ADD = SW'(W_WORDS - 1);
  localparam logic [SW-1:0] LAST_MUL = SW'(MULT_BITS - 1);

  state_e               state_q, state_d;
  logic                 op_q, op_d;
  logic                 cout_q, cout_d;
  logic                 valid_q, valid_d;
  logic [SW-1:0]        idx_q, idx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 cf_q, cf_d;
  logic                 msel_q, msel_d;
  logic [1:0]           mode_q, mode_d;
  logic [MULT_BITS-1:0] mult_q, mult_d;

  logic                 in_idle;
  logic                 last_step;
  logic [SW-1:0]        nxt_idx;
  logic                 run_bit;
  logic                 dec_msel;
  logic [1:0]           dec_mode;
  logic                 dec_bit;
  logic                 dec_op;
  logic                 dec_carry;

  assign in_idle   = (state_q == ST_IDLE);
  assign nxt_idx   = idx_q + SW'(1);
  assign last_step = (idx_q == (msel_q ? LAST_MUL : LAST_ADD));

  always_comb begin
    run_bit = 1'b0;
    for (int unsigned i = 0; i < MULT_BITS; i++) begin
      if (SW'(i) == nxt_idx) run_bit = mult_q[i];
    end
  end

  // In IDLE the decoder sees the live request so step 0 can be issued on the start edge;
  // during RUN it sees the latched operands and the next multiplier bit.
  assign dec_msel = in_idle ? bus.mult_sel      : msel_q;
  assign dec_mode = in_idle ? bus.mode          : mode_q;
  assign dec_bit  = in_idle ? bus.multiplier[0] : run_bit;

  alu_carry_dec u_carry_dec (
    .mult_sel (dec_msel),
    .mode     (dec_mode),
    .cin      (bus.cin),
    .mult_bit (dec_bit),
    .op       (dec_op),
    .carry    (dec_carry)
  );

  always_comb begin
    state_d = state_q;
    op_d    = 1'b0;
    cout_d  = 1'b0;
    valid_d = 1'b0;
    idx_d   = '0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    cf_d    = cf_q;
    msel_d  = msel_q;
    mode_d  = mode_q;
    mult_d  = mult_q;
    if (bus.flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_d = ST_RUN;
            msel_d  = bus.mult_sel;
            mode_d  = bus.mode;
            mult_d  = bus.multiplier;
            op_d    = dec_op;
            cout_d  = dec_carry;
            valid_d = 1'b1;
            busy_d  = 1'b1;
          end
        end
        ST_RUN: begin
          busy_d = 1'b1;
          if (last_step) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            cf_d    = msel_q ? 1'b0 : bus.unit_cout;
          end else begin
            op_d    = dec_op;
            cout_d  = msel_q ? 1'b0 : bus.unit_cout;
            valid_d = 1'b1;
            idx_d   = nxt_idx;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= 1'b0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cf_q    <= 1'b0;
      msel_q  <= 1'b0;
      mode_q  <= '0;
      mult_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cout_q  <= cout_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cf_q    <= cf_d;
      msel_q  <= msel_d;
      mode_q  <= mode_d;
      mult_q  <= mult_d;
    end
  end

  assign bus.op_out     = op_q;
  assign bus.cout       = cout_q;
  assign bus.step_valid = valid_q;
  assign bus.step_idx   = idx_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.carry_flag = cf_q;

endmodule

// File: tb/tb_alu_op_seq.sv
// Randomized bench for alu_op_seq against a per-operation expected step list.
module tb_alu_op_seq;
  import alu_op_pkg::*;

  localparam int unsigned W  = 4;
  localparam int unsigned M  = 8;
  localparam int unsigned SW = sw_calc(W, M);
  localparam int unsigned VW = SW + 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_op_seq_if #(.MULT_BITS(M), .SW(SW)) bus ();

  alu_op_seq #(.W_WORDS(W), .MULT_BITS(M), .SW(SW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   checks = 0;
  int   errors = 0;
  logic exp_cf = 1'b0;

  function automatic logic [VW-1:0] obs();
    return {bus.step_valid, bus.step_idx, bus.op_out, bus.cout, bus.busy, bus.done, bus.carry_flag};
  endfunction

  function automatic logic [VW-1:0] expv(logic v, int unsigned idx, logic op, logic c,
                                         logic b, logic d, logic cf);
    return {v, SW'(idx), op, c, b, d, cf};
  endfunction

  // Carry-in of the first word: subtraction is addition of the inverted operand,
  // so its incoming carry is the inverse of the borrow (or 1 with no borrow).
  function automatic logic first_carry(logic [1:0] md, logic ci);
    logic chained;
    chained = md[0] ? ci : 1'b0;
    return md[1] ? ~chained : chained;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start      = 1'b0;
    bus.mult_sel   = 1'b0;
    bus.mode       = 2'b00;
    bus.cin        = 1'b0;
    bus.multiplier = '0;
    bus.unit_cout  = 1'b0;
    bus.flush      = 1'b0;
  endtask

  task automatic test_reset();
    logic [VW-1:0] e;
    bus.start = 1'b1; bus.mult_sel = 1'b1; bus.multiplier = 8'hFF; bus.unit_cout = 1'b1;
    rst_n = 1'b0;
    tick(); tick();
    exp_cf = 1'b0;
    e = expv(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL reset_state: got %b want %b", obs(), e); end
    idle_inputs();
    rst_n = 1'b1;
    tick();
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL reset_release: got %b want %b", obs(), e); end
  endtask

  task automatic test_addsub(input logic [1:0] md, input logic ci, input logic [W-1:0] u,
                             input string name);
    logic [VW-1:0] e;
    bus.start = 1'b1; bus.mult_sel = 1'b0; bus.mode = md; bus.cin = ci;
    bus.multiplier = M'($urandom);
    tick();
    bus.start = 1'b0; bus.mode = 2'($urandom); bus.cin = 1'($urandom);
    for (int unsigned k = 0; k < W; k++) begin
      e = expv(1, k, md[1], (k == 0) ? first_carry(md, ci) : u[k-1], 1, 0, exp_cf);
      checks++;
      if (obs() !== e) begin errors++; $display("FAIL %s step %0d: got %b want %b", name, k, obs(), e); end
      bus.unit_cout = u[k];
      tick();
    end
    exp_cf = u[W-1];
    e = expv(0, 0, 0, 0, 1, 1, exp_cf);
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL %s done: got %b want %b", name, obs(), e); end
    bus.unit_cout = 1'($urandom);
    tick();
    e = expv(0, 0, 0, 0, 0, 0, exp_cf);
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL %s idle: got %b want %b", name, obs(), e); end
    bus.unit_cout = 1'b0;
  endtask

  task automatic test_mult(input logic [M-1:0] mv, input string name);
    logic [VW-1:0] e;
    bus.start = 1'b1; bus.mult_sel = 1'b1; bus.mode = 2'($urandom); bus.cin = 1'($urandom);
    bus.multiplier = mv;
    tick();
    bus.start = 1'b0; bus.multiplier = M'($urandom); bus.mult_sel = 1'b0;
    for (int unsigned k = 0; k < M; k++) begin
      e = expv(1, k, mv[k], 0, 1, 0, exp_cf);
      checks++;
      if (obs() !== e) begin errors++; $display("FAIL %s step %0d: got %b want %b", name, k, obs(), e); end
      bus.unit_cout = 1'($urandom);
      tick();
    end
    exp_cf = 1'b0;
    e = expv(0, 0, 0, 0, 1, 1, exp_cf);
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL %s done: got %b want %b", name, obs(), e); end
    tick();
    e = expv(0, 0, 0, 0, 0, 0, exp_cf);
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL %s idle: got %b want %b", name, obs(), e); end
    bus.unit_cout = 1'b0;
  endtask

  task automatic test_flush();
    logic [VW-1:0] e;
    bus.start = 1'b1; bus.mult_sel = 1'b0; bus.mode = 2'b00; bus.cin = 1'b0;
    tick();
    bus.start = 1'b0;
    for (int unsigned k = 0; k < 2; k++) begin
      bus.unit_cout = ~exp_cf;
      tick();
    end
    e = expv(1, 2, 0, ~exp_cf, 1, 0, exp_cf);
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL flush_pre step2: got %b want %b", obs(), e); end
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0; bus.unit_cout = 1'b0;
    e = expv(0, 0, 0, 0, 0, 0, exp_cf);
    for (int unsigned c = 0; c < 6; c++) begin
      checks++;
      if (obs() !== e) begin errors++; $display("FAIL flush_idle cycle %0d: got %b want %b", c, obs(), e); end
      tick();
    end
    bus.start = 1'b1; bus.flush = 1'b1;
    tick();
    bus.start = 1'b0; bus.flush = 1'b0;
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL flush_over_start: got %b want %b", obs(), e); end
    tick();
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL flush_over_start_next: got %b want %b", obs(), e); end
  endtask

  task automatic test_back_to_back();
    logic [VW-1:0] e;
    logic          ci_lat;
    logic          u_prev;
    bus.start = 1'b1; bus.mult_sel = 1'b0; bus.mode = 2'b11;
    ci_lat = 1'($urandom);
    bus.cin = ci_lat;
    tick();
    for (int unsigned op = 0; op < 3; op++) begin
      u_prev = 1'b0;
      for (int unsigned k = 0; k < W; k++) begin
        e = expv(1, k, 1, (k == 0) ? ~ci_lat : u_prev, 1, 0, exp_cf);
        checks++;
        if (obs() !== e) begin errors++; $display("FAIL b2b op %0d step %0d: got %b want %b", op, k, obs(), e); end
        u_prev = 1'($urandom);
        bus.unit_cout = u_prev;
        bus.cin = 1'($urandom);
        tick();
      end
      exp_cf = u_prev;
      e = expv(0, 0, 0, 0, 1, 1, exp_cf);
      checks++;
      if (obs() !== e) begin errors++; $display("FAIL b2b op %0d done: got %b want %b", op, obs(), e); end
      bus.cin = 1'($urandom);
      tick();
      e = expv(0, 0, 0, 0, 0, 0, exp_cf);
      checks++;
      if (obs() !== e) begin errors++; $display("FAIL b2b op %0d gap: got %b want %b", op, obs(), e); end
      ci_lat = 1'($urandom);
      bus.cin = ci_lat;
      if (op == 2) bus.start = 1'b0;
      tick();
    end
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL b2b stop: got %b want %b", obs(), e); end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    logic [VW-1:0] e;
    logic [M-1:0]  mv;
    mv = M'($urandom);
    bus.start = 1'b1; bus.mult_sel = 1'b1; bus.multiplier = mv;
    tick();
    bus.start = 1'b0;
    tick(); tick(); tick();
    e = expv(1, 3, mv[3], 0, 1, 0, exp_cf);
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL rst_mid pre step3: got %b want %b", obs(), e); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_cf = 1'b0;
    e = expv(0, 0, 0, 0, 0, 0, 0);
    for (int unsigned c = 0; c < 10; c++) begin
      checks++;
      if (obs() !== e) begin errors++; $display("FAIL rst_mid cycle %0d: got %b want %b", c, obs(), e); end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    test_reset();
    test_addsub(2'b00, 1'b0, 4'b1101, "add_req037");
    test_addsub(2'b11, 1'b1, W'($urandom), "sbc_cin1");
    test_addsub(2'b11, 1'b0, W'($urandom), "sbc_cin0");
    test_mult(8'hA5, "mult_a5");
    for (int unsigned r = 0; r < 6; r++) begin
      test_addsub(2'($urandom), 1'($urandom), W'($urandom), "addsub_rand");
      test_mult(M'($urandom), "mult_rand");
    end
    test_addsub(2'b00, 1'b0, 4'b1000, "add_set_cf");
    test_flush();
    test_back_to_back();
    test_addsub(2'b10, 1'b0, 4'b1000, "sub_set_cf");
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
